// File: rtl/race_sequencer_if.sv
// Race sequencer control/status bundle.
// master drives the requests, slave is the sequencer.
interface race_sequencer_if;
  logic        start_btn;
  logic        pause_btn;
  logic        abort;
  logic        p1_finish;
  logic        p2_finish;
  logic [2:0]  state;
  logic [2:0]  countdown;
  logic [1:0]  winner;
  logic [13:0] race_time;
  logic        state_pulse;

  modport master (
    output start_btn,
    output pause_btn,
    output abort,
    output p1_finish,
    output p2_finish,
    input  state,
    input  countdown,
    input  winner,
    input  race_time,
    input  state_pulse
  );

  modport slave (
    input  start_btn,
    input  pause_btn,
    input  abort,
    input  p1_finish,
    input  p2_finish,
    output state,
    output countdown,
    output winner,
    output race_time,
    output state_pulse
  );
endinterface

// File: rtl/race_sequencer.sv
// Race game sequencer: IDLE/SETTING/COUNTDOWN/RACING/PAUSE/FINISH,
// countdown seconds, centisecond race timer and winner latch.
module race_sequencer #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int COUNT_SECONDS = 3,
  parameter int TIME_MAX      = 9999
) (
  input  logic             clk,
  input  logic             rst,
  race_sequencer_if.slave  bus
);

  localparam int CS_DIV = CLK_FREQ / 100;
  localparam int SEC_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_FREQ - 1);
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(CS_DIV - 1);
  localparam logic [13:0]      T_MAX    = 14'(TIME_MAX);
  localparam logic [2:0]       CD_LOAD  = 3'(COUNT_SECONDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_CD    = 3'd3,
    S_RACE  = 3'd4,
    S_PAUSE = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  logic [1:0] rs_q, rs_d;
  logic       rst_n_i;

  state_t           state_q, state_d;
  logic [2:0]       cd_q, cd_d;
  logic [1:0]       win_q, win_d;
  logic [13:0]      time_q, time_d;
  logic             pulse_q, pulse_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [CS_W-1:0]  cs_q, cs_d;
  logic             st_prev_q, st_prev_d;
  logic             st_arm_q, st_arm_d;
  logic             pa_prev_q, pa_prev_d;
  logic             pa_arm_q, pa_arm_d;

  logic start_ev, pause_ev, any_fin;
  logic sec_tick, cs_tick, cd_entry;

  // Reset asserts at once, releases two clocks later in step with clk.
  always_comb rs_d = {rs_q[0], 1'b1};

  // Reset release synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs_q <= 2'b00;
    else      rs_q <= rs_d;
  end

  assign rst_n_i = rs_q[1];

  // Edge detect, next state, timers and winner.
  always_comb begin
    // A button only arms once it has been seen low after reset,
    // so a level held through reset release yields no event.
    st_prev_d = bus.start_btn;
    pa_prev_d = bus.pause_btn;
    st_arm_d  = st_arm_q | ~bus.start_btn;
    pa_arm_d  = pa_arm_q | ~bus.pause_btn;
    start_ev  = bus.start_btn & ~st_prev_q & st_arm_q;
    pause_ev  = bus.pause_btn & ~pa_prev_q & pa_arm_q;
    any_fin   = bus.p1_finish | bus.p2_finish;

    sec_tick = (state_q == S_CD) && (sec_q == SEC_LAST);
    cs_tick  = (state_q == S_RACE) && (cs_q == CS_LAST);

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ev) state_d = S_SET;
      S_SET:   if (start_ev) state_d = S_CD;
      S_CD:    if (sec_tick && cd_q == 3'd1) state_d = S_RACE;
      S_RACE: begin
        if (any_fin)       state_d = S_FIN;
        else if (pause_ev) state_d = S_PAUSE;
      end
      S_PAUSE: if (pause_ev) state_d = S_RACE;
      S_FIN:   if (start_ev) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;

    cd_entry = (state_d == S_CD) && (state_q != S_CD);

    sec_d = sec_q;
    if (cd_entry)              sec_d = '0;
    else if (sec_tick)         sec_d = '0;
    else if (state_q == S_CD)  sec_d = sec_q + 1'b1;

    cd_d = cd_q;
    if (state_d != S_CD) cd_d = 3'd0;
    else if (cd_entry)   cd_d = CD_LOAD;
    else if (sec_tick)   cd_d = cd_q - 3'd1;

    // Held outside RACING so pausing adds no drift.
    cs_d = cs_q;
    if (cd_entry)               cs_d = '0;
    else if (cs_tick)           cs_d = '0;
    else if (state_q == S_RACE) cs_d = cs_q + 1'b1;

    time_d = time_q;
    if (cd_entry)                     time_d = 14'd0;
    else if (cs_tick && time_q < T_MAX) time_d = time_q + 14'd1;

    win_d = win_q;
    if (state_d == S_IDLE && state_q != S_IDLE)
      win_d = 2'd0;
    else if (state_q == S_RACE && state_d == S_FIN)
      win_d = {bus.p2_finish, bus.p1_finish};

    pulse_d = (state_d != state_q);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cd_q      <= 3'd0;
      win_q     <= 2'd0;
      time_q    <= 14'd0;
      pulse_q   <= 1'b0;
      sec_q     <= '0;
      cs_q      <= '0;
      st_prev_q <= 1'b0;
      st_arm_q  <= 1'b0;
      pa_prev_q <= 1'b0;
      pa_arm_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      win_q     <= win_d;
      time_q    <= time_d;
      pulse_q   <= pulse_d;
      sec_q     <= sec_d;
      cs_q      <= cs_d;
      st_prev_q <= st_prev_d;
      st_arm_q  <= st_arm_d;
      pa_prev_q <= pa_prev_d;
      pa_arm_q  <= pa_arm_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.countdown   = cd_q;
  assign bus.winner      = win_q;
  assign bus.race_time   = time_q;
  assign bus.state_pulse = pulse_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed race scenarios plus random play,
// every cycle scored against a time-based reference model.
module tb_race_sequencer;

  localparam int CF  = 1000;
  localparam int CSN = 3;
  localparam int TM  = 60;
  localparam int CSD = CF / 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  race_sequencer_if bus();

  race_sequencer #(
    .CLK_FREQ(CF),
    .COUNT_SECONDS(CSN),
    .TIME_MAX(TM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  cd;
    logic [1:0]  win;
    logic [13:0] t;
    logic        p;
  } obs_t;

  obs_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  // Reference model: state plus elapsed-cycle counts.
  int m_state, m_cd_cyc, m_race_cyc, m_win, m_hold;
  bit m_pulse, m_ps, m_pp;

  logic r_i, s_i, p_i, a_i, f1_i, f2_i;

  // Level seen before reset counts as high: no event until it drops.
  task automatic model_reset();
    m_state = 0;
    m_cd_cyc = 0;
    m_race_cyc = 0;
    m_win = 0;
    m_pulse = 0;
    m_ps = 1;
    m_pp = 1;
  endtask

  task automatic model_edge();
    int old, nxt;
    bit se, pe;
    if (!rst) begin
      model_reset();
      m_hold = 2;
      return;
    end
    if (m_hold > 0) begin
      m_hold--;
      model_reset();
      return;
    end
    se = bus.start_btn && !m_ps;
    pe = bus.pause_btn && !m_pp;
    m_ps = bus.start_btn;
    m_pp = bus.pause_btn;
    old = m_state;
    nxt = old;
    if (old == 4) m_race_cyc++;
    if (old == 3) m_cd_cyc++;
    if (bus.abort) nxt = 0;
    else case (old)
      0: if (se) nxt = 1;
      1: if (se) nxt = 3;
      3: if (m_cd_cyc == CSN * CF) nxt = 4;
      4: begin
        if (bus.p1_finish || bus.p2_finish) begin
          nxt = 6;
          m_win = (bus.p1_finish ? 1 : 0) + (bus.p2_finish ? 2 : 0);
        end else if (pe) nxt = 5;
      end
      5: if (pe) nxt = 4;
      6: if (se) nxt = 0;
      default: nxt = 0;
    endcase
    if (nxt == 3 && old != 3) begin
      m_cd_cyc = 0;
      m_race_cyc = 0;
    end
    if (nxt == 0 && old != 0) m_win = 0;
    m_pulse = (nxt != old);
    m_state = nxt;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int t;
    o.st = 3'(m_state);
    o.cd = (m_state == 3) ? 3'(CSN - m_cd_cyc / CF) : 3'd0;
    o.win = 2'(m_win);
    t = m_race_cyc / CSD;
    o.t = 14'((t > TM) ? TM : t);
    o.p = m_pulse;
    return o;
  endfunction

  // One clock: score the edge just taken, then apply next inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    rst = r_i;
    bus.start_btn = s_i;
    bus.pause_btn = p_i;
    bus.abort = a_i;
    bus.p1_finish = f1_i;
    bus.p2_finish = f2_i;
    if (!r_i) begin
      model_reset();
      m_hold = 2;
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_start();
    s_i = 1; run(2);
    s_i = 0; run(2);
  endtask

  task automatic press_pause();
    p_i = 1; run(2);
    p_i = 0; run(2);
  endtask

  // Monitor: every negedge the DUT outputs are scored.
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.st  = bus.state;
        g.cd  = bus.countdown;
        g.win = bus.winner;
        g.t   = bus.race_time;
        g.p   = bus.state_pulse;
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs cyc%0d: got st=%0d cd=%0d win=%0d t=%0d p=%0d want st=%0d cd=%0d win=%0d t=%0d p=%0d",
                   cyc_n, g.st, g.cd, g.win, g.t, g.p,
                   e.st, e.cd, e.win, e.t, e.p);
        end
      end
    end
  end

  initial begin
    model_reset();
    m_hold = 2;
    r_i = 0; s_i = 0; p_i = 0; a_i = 0; f1_i = 0; f2_i = 0;
    bus.start_btn = 0;
    bus.pause_btn = 0;
    bus.abort = 0;
    bus.p1_finish = 0;
    bus.p2_finish = 0;

    // Reset, then start twice into COUNTDOWN and through to RACING.
    run(4);
    r_i = 1; run(6);
    press_start();
    run(5);
    s_i = 1; run(1);
    s_i = 0; run(3010);

    // Race, pause, resume.
    run(240);
    p_i = 1; run(1);
    p_i = 0; run(399);
    p_i = 1; run(1);
    p_i = 0; run(249);

    // Tie finish, frozen time, start back to IDLE.
    f1_i = 1; f2_i = 1; run(1);
    run(30);
    f1_i = 0; f2_i = 0; run(5);
    press_start();

    // Pause and p2 finish rise together: finish wins.
    press_start();
    press_start();
    run(3020);
    p_i = 1; f2_i = 1; run(1);
    run(5);
    p_i = 0; f2_i = 0; run(5);
    press_start();

    // Saturate timer, then p1 finish held in PAUSE.
    press_start();
    press_start();
    run(3700);
    press_pause();
    f1_i = 1; run(40);
    press_pause();
    f1_i = 0; run(5);
    press_start();

    // Abort mid-race.
    press_start();
    press_start();
    run(3100);
    a_i = 1; f2_i = 1; run(1);
    a_i = 0; f2_i = 0; run(5);

    // Reset mid-countdown with start held through release.
    press_start();
    press_start();
    run(1500);
    s_i = 1; r_i = 0; run(3);
    r_i = 1; run(20);
    s_i = 0; run(3);
    s_i = 1; run(3);
    s_i = 0; run(3);

    // Random play.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) s_i = ~s_i;
      if ($urandom_range(0, 79) == 0) p_i = ~p_i;
      a_i = ($urandom_range(0, 2999) == 0);
      if (!f1_i && $urandom_range(0, 1499) == 0) f1_i = 1;
      else if (f1_i && $urandom_range(0, 3) == 0) f1_i = 0;
      if (!f2_i && $urandom_range(0, 1499) == 0) f2_i = 1;
      else if (f2_i && $urandom_range(0, 3) == 0) f2_i = 0;
      r_i = ($urandom_range(0, 9999) != 0);
      run(1);
    end

    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
